// File: rtl/oflow_score_calc_calc_min.sv
// ---------------------------------------------------------------------------
// oflow_score_calc_calc_min
//
// Minimum-search engine of the score-calc stage. A start pulse latches one
// batch of N_CAND candidate scores, which are then scanned one per clock. A
// running minimum (score + candidate ID) is kept and carries across the
// batches of one object until a start with first_batch=1 clears it.
// done_calc_min pulses for one cycle when the batch scan completes.
//
// Parameters:
//   SCORE_W   width of one unsigned score
//   N_CAND    candidates per batch (>= 2)
//   ID_W      candidate ID width
//   SCORE_TH  match threshold (exists only with OFLOW_CALC_MIN_THRESHOLD_EN)
//
// Optional feature macro: OFLOW_CALC_MIN_THRESHOLD_EN
//   Defined   : a candidate also needs score <= SCORE_TH to qualify.
//   Undefined : every unmasked candidate participates.
//
// Ports:
//   clk              in   clock, rising edge
//   reset_N          in   asynchronous active-low reset
//   start_calc_min   in   one-cycle start pulse (ignored while busy)
//   first_batch      in   sampled with start; clears the running minimum
//   scores_in        in   packed scores, candidate k at [k*SCORE_W +: SCORE_W]
//   valid_mask       in   bit k=1: candidate k participates
//   batch_base_id    in   ID of candidate 0 (candidate k = base + k, wraps)
//   done_calc_min    out  one-cycle pulse at end of batch scan
//   busy             out  high from start edge until done cycle ends
//   min_score        out  running minimum score
//   min_id           out  ID of the running minimum
//   min_found        out  at least one candidate qualified since last clear
// ---------------------------------------------------------------------------
module oflow_score_calc_calc_min #(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned N_CAND  = 8,
    parameter int unsigned ID_W    = 10
`ifdef OFLOW_CALC_MIN_THRESHOLD_EN
    ,
    parameter logic [SCORE_W-1:0] SCORE_TH = SCORE_W'(16'h0FFF)
`endif
) (
    input  logic                      clk,
    input  logic                      reset_N,
    input  logic                      start_calc_min,
    input  logic                      first_batch,
    input  logic [N_CAND*SCORE_W-1:0] scores_in,
    input  logic [N_CAND-1:0]         valid_mask,
    input  logic [ID_W-1:0]           batch_base_id,
    output logic                      done_calc_min,
    output logic                      busy,
    output logic [SCORE_W-1:0]        min_score,
    output logic [ID_W-1:0]           min_id,
    output logic                      min_found
);

    localparam int unsigned IDX_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SCORE_W-1:0]   scores_q [N_CAND];
    logic [SCORE_W-1:0]   scores_d [N_CAND];
    logic [N_CAND-1:0]    mask_q, mask_d;
    logic [ID_W-1:0]      base_q, base_d;
    logic [SCORE_W-1:0]   min_score_q, min_score_d;
    logic [ID_W-1:0]      min_id_q, min_id_d;
    logic                 min_found_q, min_found_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [SCORE_W-1:0]   cand_score_c;
    logic [ID_W-1:0]      cand_id_c;
    logic                 th_ok_c;
    logic                 qualify_c;

    // Current candidate under scan, taken from the latched batch copy.
    always_comb begin
        cand_score_c = scores_q[idx_q];
        cand_id_c    = base_q + ID_W'(idx_q);
`ifdef OFLOW_CALC_MIN_THRESHOLD_EN
        th_ok_c      = (cand_score_c <= SCORE_TH);
`else
        th_ok_c      = 1'b1;
`endif
        // Strict less-than keeps the earlier candidate on ties.
        qualify_c    = mask_q[idx_q] & th_ok_c &
                       (~min_found_q | (cand_score_c < min_score_q));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scores_d    = scores_q;
        mask_d      = mask_q;
        base_d      = base_q;
        min_score_d = min_score_q;
        min_id_d    = min_id_q;
        min_found_d = min_found_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start_calc_min) begin
                    for (int unsigned k = 0; k < N_CAND; k++) begin
                        scores_d[k] = scores_in[k*SCORE_W +: SCORE_W];
                    end
                    mask_d  = valid_mask;
                    base_d  = batch_base_id;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                    if (first_batch) begin
                        min_score_d = '1;
                        min_id_d    = '0;
                        min_found_d = 1'b0;
                    end
                end
            end
            ST_SCAN: begin
                if (qualify_c) begin
                    min_score_d = cand_score_c;
                    min_id_d    = cand_id_c;
                    min_found_d = 1'b1;
                end
                if (idx_q == IDX_W'(N_CAND - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            for (int unsigned k = 0; k < N_CAND; k++) begin
                scores_q[k] <= '0;
            end
            mask_q      <= '0;
            base_q      <= '0;
            min_score_q <= '1;
            min_id_q    <= '0;
            min_found_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scores_q    <= scores_d;
            mask_q      <= mask_d;
            base_q      <= base_d;
            min_score_q <= min_score_d;
            min_id_q    <= min_id_d;
            min_found_q <= min_found_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign done_calc_min = done_q;
    assign busy          = busy_q;
    assign min_score     = min_score_q;
    assign min_id        = min_id_q;
    assign min_found     = min_found_q;

endmodule

// File: tb/tb_oflow_score_calc_calc_min.sv
// ---------------------------------------------------------------------------
// Bench for oflow_score_calc_calc_min: directed batches, a cycle-level model
// of the running minimum compared on every falling edge, plus literal
// expectations for the hand-worked cases.
// ---------------------------------------------------------------------------
module tb_oflow_score_calc_calc_min;

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned N_CAND  = 8;
    localparam int unsigned ID_W    = 10;
`ifdef OFLOW_CALC_MIN_THRESHOLD_EN
    localparam logic [SCORE_W-1:0] TH = 16'd100;
`endif

    logic                      clk;
    logic                      reset_N;
    logic                      start_calc_min;
    logic                      first_batch;
    logic [N_CAND*SCORE_W-1:0] scores_in;
    logic [N_CAND-1:0]         valid_mask;
    logic [ID_W-1:0]           batch_base_id;
    logic                      done_calc_min;
    logic                      busy;
    logic [SCORE_W-1:0]        min_score;
    logic [ID_W-1:0]           min_id;
    logic                      min_found;

    oflow_score_calc_calc_min #(
        .SCORE_W (SCORE_W),
        .N_CAND  (N_CAND),
        .ID_W    (ID_W)
`ifdef OFLOW_CALC_MIN_THRESHOLD_EN
        ,
        .SCORE_TH(TH)
`endif
    ) dut (
        .clk           (clk),
        .reset_N       (reset_N),
        .start_calc_min(start_calc_min),
        .first_batch   (first_batch),
        .scores_in     (scores_in),
        .valid_mask    (valid_mask),
        .batch_base_id (batch_base_id),
        .done_calc_min (done_calc_min),
        .busy          (busy),
        .min_score     (min_score),
        .min_id        (min_id),
        .min_found     (min_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Running result (what the outputs show once a batch is final), the
    // pending result of the batch in flight, and a cycle count since start.
    logic               m_busy = 1'b0;
    logic               m_done = 1'b0;
    int                 m_cnt  = 0;
    logic [SCORE_W-1:0] run_s  = '1;
    logic [ID_W-1:0]    run_id = '0;
    logic               run_f  = 1'b0;
    logic [SCORE_W-1:0] pend_s;
    logic [ID_W-1:0]    pend_id;
    logic               pend_f;

    function automatic logic thr_ok(input logic [SCORE_W-1:0] s);
`ifdef OFLOW_CALC_MIN_THRESHOLD_EN
        return s <= TH;
`else
        return (s == s);
`endif
    endfunction

    always @(posedge clk or negedge reset_N) begin : mdl
        logic [SCORE_W-1:0] s;
        logic [SCORE_W-1:0] bs;
        int                 best;
        if (!reset_N) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            run_s  = '1;
            run_id = '0;
            run_f  = 1'b0;
        end else if (!m_busy) begin
            if (start_calc_min) begin
                pend_s  = first_batch ? '1 : run_s;
                pend_id = first_batch ? '0 : run_id;
                pend_f  = first_batch ? 1'b0 : run_f;
                // Lowest-index minimum of the batch, then merge with the
                // running result (earlier batch wins ties).
                best = -1;
                bs   = '1;
                for (int k = 0; k < N_CAND; k++) begin
                    s = scores_in[k*SCORE_W +: SCORE_W];
                    if (valid_mask[k] && thr_ok(s) && (best < 0 || s < bs)) begin
                        best = k;
                        bs   = s;
                    end
                end
                if (best >= 0 && (!pend_f || bs < pend_s)) begin
                    pend_s  = bs;
                    pend_id = batch_base_id + ID_W'(best);
                    pend_f  = 1'b1;
                end
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == N_CAND) begin
                m_done = 1'b1;
                run_s  = pend_s;
                run_id = pend_id;
                run_f  = pend_f;
            end else if (m_cnt == N_CAND + 1) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    // Every-cycle compare; results only when final (idle or done cycle).
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done_calc_min), 32'(m_done));
        if (done_calc_min === 1'b1) done_cnt++;
        if (!m_busy || m_done) begin
            chk("min_score", 32'(min_score), 32'(run_s));
            chk("min_id", 32'(min_id), 32'(run_id));
            chk("min_found", 32'(min_found), 32'(run_f));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [N_CAND*SCORE_W-1:0] pk(input int unsigned v[8]);
        logic [N_CAND*SCORE_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CAND; k++) r[k*SCORE_W +: SCORE_W] = SCORE_W'(v[k]);
        return r;
    endfunction

    task automatic scramble();
        scores_in     = {$urandom, $urandom, $urandom, $urandom};
        valid_mask    = N_CAND'($urandom);
        batch_base_id = ID_W'($urandom);
        first_batch   = 1'($urandom);
    endtask

    task automatic drive_start(input logic first, input logic [N_CAND*SCORE_W-1:0] sc,
                               input logic [N_CAND-1:0] m, input logic [ID_W-1:0] b);
        @(negedge clk);
        first_batch    = first;
        scores_in      = sc;
        valid_mask     = m;
        batch_base_id  = b;
        start_calc_min = 1'b1;
        @(negedge clk);
        start_calc_min = 1'b0;
        scramble();
    endtask

    // Waits for done; lat counts falling edges from the start-assert edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done_calc_min !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done_calc_min !== 1'b1) chk("done_timeout", 32'(done_calc_min), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_batch(input logic first, input logic [N_CAND*SCORE_W-1:0] sc,
                             input logic [N_CAND-1:0] m, input logic [ID_W-1:0] b);
        int lat;
        drive_start(first, sc, m, b);
        wait_done(lat);
        chk("latency", 32'(lat), 32'(N_CAND + 1));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int lat;
        reset_N        = 1'b0;
        start_calc_min = 1'b0;
        first_batch    = 1'b0;
        scores_in      = '0;
        valid_mask     = '0;
        batch_base_id  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_calc_min), 32'd0);
        chk("rst_score", 32'(min_score), 32'hFFFF);
        chk("rst_id", 32'(min_id), 32'd0);
        chk("rst_found", 32'(min_found), 32'd0);
        #2 reset_N = 1'b1;

        // Batch 1: min 10 at k5 (tie with k6 keeps k5).
        run_batch(1'b1, pk('{50, 30, 70, 30, 90, 10, 10, 40}), 8'hFF, 10'd100);
        chk("b1_score", 32'(min_score), 32'd10);
        chk("b1_id", 32'(min_id), 32'd105);
        chk("b1_found", 32'(min_found), 32'd1);

        // Batch 2 carries over: 5 at k2 beats 10.
        run_batch(1'b0, pk('{20, 20, 5, 20, 20, 20, 20, 20}), 8'hFF, 10'd200);
        chk("b2_score", 32'(min_score), 32'd5);
        chk("b2_id", 32'(min_id), 32'd202);

        // Equal scores in a later batch do not displace the earlier one.
        run_batch(1'b0, pk('{5, 5, 5, 5, 5, 5, 5, 5}), 8'hFF, 10'd300);
        chk("b3_score", 32'(min_score), 32'd5);
        chk("b3_id", 32'(min_id), 32'd202);

        // Empty mask with clear.
        run_batch(1'b1, pk('{1, 2, 3, 4, 5, 6, 7, 8}), 8'h00, 10'd400);
        chk("m0_found", 32'(min_found), 32'd0);
        chk("m0_score", 32'(min_score), 32'hFFFF);
        chk("m0_id", 32'(min_id), 32'd0);

        // Start during scan is ignored; ID wraps 1020+6 -> 2.
        d0 = done_cnt;
        drive_start(1'b1, pk('{100, 90, 80, 70, 60, 50, 7, 30}), 8'hFF, 10'd1020);
        @(negedge clk);
        @(negedge clk);
        first_batch    = 1'b1;
        scores_in      = '0;
        valid_mask     = '1;
        batch_base_id  = 10'd7;
        start_calc_min = 1'b1;
        @(negedge clk);
        start_calc_min = 1'b0;
        scramble();
        wait_done(lat);
        repeat (3) @(negedge clk);
        chk("ign_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("ign_score", 32'(min_score), 32'd7);
        chk("ign_id", 32'(min_id), 32'd2);

        // Reset in the middle of a scan.
        d0 = done_cnt;
        drive_start(1'b0, pk('{3, 3, 3, 3, 3, 3, 3, 3}), 8'hFF, 10'd500);
        repeat (3) @(negedge clk);
        #2 reset_N = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_score", 32'(min_score), 32'hFFFF);
        chk("mid_rst_found", 32'(min_found), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_N = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        run_batch(1'b0, pk('{50, 30, 70, 30, 90, 10, 10, 40}), 8'hFF, 10'd100);
        chk("post_rst_id", 32'(min_id), 32'd105);

        // Threshold behaviour.
        run_batch(1'b1, pk('{200, 200, 200, 200, 200, 200, 200, 200}), 8'hFF, 10'd600);
`ifdef OFLOW_CALC_MIN_THRESHOLD_EN
        chk("th_all_found", 32'(min_found), 32'd0);
        run_batch(1'b1, pk('{200, 200, 200, 99, 200, 200, 200, 200}), 8'hFF, 10'd600);
        chk("th_k3_id", 32'(min_id), 32'd603);
        chk("th_k3_found", 32'(min_found), 32'd1);
`else
        chk("nth_all_found", 32'(min_found), 32'd1);
        chk("nth_all_id", 32'(min_id), 32'd600);
`endif

        // Partial masks and max-score edge cases, checked by the model.
        run_batch(1'b1, pk('{65535, 9, 65535, 4, 4, 65534, 0, 1}), 8'b1011_0101, 10'd1023);
        run_batch(1'b0, pk('{0, 8, 8, 8, 8, 8, 8, 8}), 8'b0000_0010, 10'd10);
        run_batch(1'b0, pk('{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535}), 8'hFF, 10'd1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/oflow_score_calc_calc_min.md
# oflow_score_calc_calc_min

Minimum-search engine of the score-calc stage. On each `start_calc_min` pulse it latches one batch of candidate similarity scores, scans them one per clock, and keeps a running minimum (score and candidate ID) that carries across the batches of one object. It pulses `done_calc_min` back to the score-calc FSM when the batch scan is complete. It sits between the similarity-metric output registers (data) and the score-calc control FSM (handshake).

## Interface
- `SCORE_W`, 16: width of one unsigned score.
- `N_CAND`, 8: candidates per batch, at least 2.
- `ID_W`, 10: candidate ID width.
- `SCORE_TH`, 16'h0FFF: match threshold; used only when the configuration macro is defined.
- `clk` in 1: clock, rising edge.
- `reset_N` in 1: asynchronous, active-low reset.
- `start_calc_min` in 1: one-cycle start pulse from the score-calc FSM.
- `first_batch` in 1: sampled with start; 1 clears the running minimum before this batch.
- `scores_in` in `N_CAND*SCORE_W`: packed scores; candidate k occupies bits `[k*SCORE_W +: SCORE_W]`.
- `valid_mask` in `N_CAND`: bit k=1 means candidate k participates.
- `batch_base_id` in `ID_W`: ID of candidate 0; candidate k has ID `batch_base_id + k`, modulo 2^ID_W.
- `done_calc_min` out 1: one-cycle pulse when the batch scan is complete.
- `busy` out 1: high from the start edge until done.
- `min_score` out `SCORE_W`: running minimum score.
- `min_id` out `ID_W`: ID of the running minimum.
- `min_found` out 1: at least one candidate has qualified since the last clear.

## Operation
- States are IDLE, SCAN and DONE.
- **IDLE:**
  - On `start_calc_min`=1, latch `scores_in`, `valid_mask` and `batch_base_id`, set idx=0 and go to SCAN.
  - If `first_batch`=1 on that edge, also set `min_score`=all-ones, `min_id`=0 and `min_found`=0.
- **SCAN:** one candidate per edge, at index idx.
  - Candidate idx qualifies if its mask bit is 1 and (`min_found`=0 or score < `min_score`, strict).
  - On a qualifying candidate, update `min_score`, `min_id` and `min_found`=1.
  - At idx=N_CAND-1, go to DONE; otherwise increment idx.
- **DONE:** `done_calc_min`=1 for this one cycle, then return to IDLE.
- Ties keep the earlier candidate: the lower index within a batch, or the earlier batch across batches.
- Comparisons are unsigned at full `SCORE_W`. The ID add wraps with no flag.
- `start_calc_min` while `busy`=1 is ignored and has no side effects.
- Input buses are don't-care except on the start edge; the engine uses only the latched copy.
- An all-zero mask completes normally with the running minimum unchanged.
- Running results persist across batches until a start with `first_batch`=1 or a reset.

## Timing
- Reset values: `done_calc_min`=0, `busy`=0, `min_score`=all-ones, `min_id`=0, `min_found`=0, state IDLE, idx=0.
- Start sampled at edge E:
  - `busy`=1 after E.
  - Candidate k is compared at edge E+1+k.
  - DONE is entered at edge E+N_CAND.
  - `done_calc_min`=1 during cycle E+N_CAND to E+N_CAND+1, with `busy` still 1.
  - `busy`=0 after edge E+N_CAND+1.
- Latency from start to done is N_CAND+1 cycles, 9 for the defaults. A new start is accepted no earlier than edge E+N_CAND+1.
- Results are final when `done_calc_min` is high and stay stable until the next start edge.
- Reset mid-scan returns every output to its reset value immediately. No `done_calc_min` is produced for the aborted batch.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `OFLOW_CALC_MIN_THRESHOLD_EN`:
  - Defined: candidate k additionally requires score ≤ `SCORE_TH` to qualify. Above-threshold candidates are treated as masked, so `min_found`=0 means "no match".
  - Undefined: `SCORE_TH` is unused and every unmasked candidate participates.

## Test plan
- Reset, then start with `first_batch`=1, scores {k0..k7}={50,30,70,30,90,10,10,40}, mask=8'hFF, base=100 -> done exactly 9 cycles after start; `min_score`=10, `min_id`=105, `min_found`=1.
- Batch 1 as above, then batch 2 with `first_batch`=0, scores all 20 except k2=5, base=200 -> `min_score`=5, `min_id`=202. A repeat batch with all scores 5, base=300 -> result stays 202.
- Start with mask=8'h00 and `first_batch`=1 -> done after 9 cycles; `min_found`=0, `min_score`=16'hFFFF, `min_id`=0.
- Second `start_calc_min` pulse 3 cycles into a scan -> ignored; exactly one done pulse and results from the first batch only. Base=1020 with min at k6 -> `min_id`=2 (wrap).
- `reset_N` low at cycle 4 of a scan -> outputs return to reset values immediately; no done pulse; next start works normally.
- With `OFLOW_CALC_MIN_THRESHOLD_EN` defined and `SCORE_TH`=100: scores all 200 -> `min_found`=0; scores all 200 except k3=99 -> `min_id`=base+3. Macro undefined, all 200 -> `min_found`=1, `min_id`=base+0.
